// File: rtl/alu_mul_seq_if.sv
// ALU operand/control bus between an initiator (the multiplier sequencer)
// and a combinational 32-bit ALU.
//   alu_a, alu_b : operands driven by the initiator
//   alu_gin      : ALU control line (operation select)
//   alu_shamt    : shift amount
//   alu_sum      : combinational ALU result returned to the initiator
// Modports: master = initiator side, slave = ALU side.
interface alu_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_gin;
  logic [4:0]       alu_shamt;
  logic [WIDTH-1:0] alu_sum;

  modport master (
    output alu_a,
    output alu_b,
    output alu_gin,
    output alu_shamt,
    input  alu_sum
  );

  modport slave (
    input  alu_a,
    input  alu_b,
    input  alu_gin,
    input  alu_shamt,
    output alu_sum
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-and-add multiplier that borrows an external
// combinational ALU for its additions, so the datapath gets a multi-cycle
// MUL without a multiplier array. One multiplier bit is retired per RUN
// cycle; RUN stops as soon as no set multiplier bits remain.
//
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start          : request a multiply, sampled only when idle
//   op_a, op_b     : multiplicand / multiplier, latched on accept
//   busy           : high from the accept edge until DONE is left
//   done           : one-cycle pulse, result/status valid
//   result         : low WIDTH bits of op_a*op_b, held until the next done
//   status         : {overflow, sign, zero} in the ALU status layout
//   alu            : master side of the ALU bus (a, b, gin, shamt -> sum)
module alu_mul_seq #(
  parameter int         WIDTH    = 32,
  parameter logic [2:0] ADD_CODE = 3'b010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       status,
  alu_mul_seq_if.master    alu
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             ovf;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;

  logic [WIDTH-1:0] mplier_next;
  logic             last_bit;
  logic             carry;
  logic             in_run;

  assign in_run      = (state == RUN);
  assign mplier_next = mplier >> 1;
  assign last_bit    = (mplier_next == '0);
  // Unsigned carry out of acc + mcand, recovered from the truncated sum.
  assign carry       = (alu.alu_sum < acc);

  // NOTE: the ALU is combinational and its sum is consumed in the same
  // cycle, so operands must come straight from acc/mcand during RUN rather
  // than through a register (which would lag one cycle). Outside RUN the
  // registered copies replay the last RUN values.
  assign alu.alu_a     = in_run ? acc   : alu_a_q;
  assign alu.alu_b     = in_run ? mcand : alu_b_q;
  assign alu.alu_gin   = ADD_CODE;
  assign alu.alu_shamt = '0;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      status  <= 3'b001;
      alu_a_q <= '0;
      alu_b_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
            ovf    <= 1'b0;
            busy   <= 1'b1;
            state  <= (op_b == '0) ? DONE : RUN;
          end
        end

        RUN: begin
          alu_a_q <= acc;
          alu_b_q <= mcand;
          if (mplier[0]) begin
            acc <= alu.alu_sum;
          end
          // Overflow: a carry out of the add, or a multiplicand bit shifted
          // out while higher multiplier bits would still have added it.
          ovf    <= ovf | (mplier[0] & carry) | (mcand[WIDTH-1] & ~last_bit);
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          if (last_bit) begin
            state <= DONE;
          end
        end

        DONE: begin
          result <= acc;
          status <= {ovf, acc[WIDTH-1], (acc == '0)};
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq: a behavioural ALU on the bus, a table of
// directed vectors, hand-written multi-cycle sequences (reset mid-run,
// start during RUN, back-to-back with start held) and random operands
// checked against a 64-bit product model.
module tb_alu_mul_seq;
  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a  = '0;
  logic [W-1:0] op_b  = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [2:0]   status;

  int errors = 0;
  int checks = 0;

  alu_mul_seq_if #(.WIDTH(W)) alu_bus ();

  // Behavioural ALU: only ADD is meaningful here; anything else yields a
  // recognisable garbage value so a wrong control line corrupts results.
  assign alu_bus.alu_sum = (alu_bus.alu_gin == 3'b010) ? (alu_bus.alu_a + alu_bus.alu_b)
                                                       : 32'hDEAD_BEEF;

  alu_mul_seq #(.WIDTH(W), .ADD_CODE(3'b010)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .status (status),
    .alu    (alu_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [2:0]   st;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: full-width product, overflow = high half nonzero,
  // latency = edges from accept to done pulse.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [2:0] s,
                                output int lat);
    logic [63:0] p;
    int msb;
    p   = {32'b0, a} * {32'b0, b};
    r   = p[31:0];
    s   = {(p[63:32] != 0), p[31], (p[31:0] == 0)};
    msb = -1;
    for (int i = 0; i < W; i++) if (b[i]) msb = i;
    lat = (msb < 0) ? 1 : msb + 2;
  endfunction

  // Launch one multiply from IDLE and wait (bounded) for its done pulse.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [2:0] s,
                       output int lat, output bit alu_ok);
    bit seen;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    check("busy_after_accept", busy, 1);
    lat    = 0;
    alu_ok = 1'b1;
    seen   = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (busy && (alu_bus.alu_gin !== 3'b010 || alu_bus.alu_shamt !== 5'd0)) alu_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    check("busy_low_at_done", busy, 0);
    r = result;
    s = status;
  endtask

  vec_t       vecs[6];
  logic [W-1:0] r, r1, r2, prev, ra, rb;
  logic [2:0] s, es;
  int         lat, l1, l2, elat, ndone;
  bit         alu_ok, stable;

  initial begin
    vecs[0] = '{a: 32'd7,          b: 32'd6,          res: 32'd42,         st: 3'b000, lat: 4};
    vecs[1] = '{a: 32'h1234_5678,  b: 32'd0,          res: 32'd0,          st: 3'b001, lat: 1};
    vecs[2] = '{a: 32'd0,          b: 32'd5,          res: 32'd0,          st: 3'b001, lat: 4};
    vecs[3] = '{a: 32'h8000_0000,  b: 32'd3,          res: 32'h8000_0000,  st: 3'b110, lat: 3};
    vecs[4] = '{a: 32'd1,          b: 32'h8000_0000,  res: 32'h8000_0000,  st: 3'b010, lat: 33};
    vecs[5] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  res: 32'd1,          st: 3'b100, lat: 33};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_status", status, 3'b001);
    check("rst_alu_a", alu_bus.alu_a, 0);
    check("rst_alu_b", alu_bus.alu_b, 0);
    check("rst_alu_gin", alu_bus.alu_gin, 3'b010);
    check("rst_alu_shamt", alu_bus.alu_shamt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, r, s, lat, alu_ok);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_status", i), s, vecs[i].st);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_alu_ctrl", i), alu_ok, 1);
    end

    // Reset mid-RUN: abort with no done pulse, outputs back to reset values.
    @(negedge clk);
    op_a  = 32'd5;
    op_b  = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_status", status, 3'b001);
    check("midrst_alu_a", alu_bus.alu_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);

    // start pulsed during RUN is ignored: exactly one done, same latency.
    @(negedge clk);
    op_a  = 32'hFFFF_FFFF;
    op_b  = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = 32'd3;
    op_b  = 32'd3;
    ndone = 0;
    l1    = 0;
    r1    = '0;
    s     = '0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          l1 = c;
          r1 = result;
          s  = status;
        end
      end
    end
    check("ignore_ndone", ndone, 1);
    check("ignore_latency", l1, 33);
    check("ignore_result", r1, 1);
    check("ignore_status", s, 3'b100);

    // Back-to-back with start held: result holds until each done.
    @(negedge clk);
    prev  = result;
    op_a  = 32'd3;
    op_b  = 32'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    op_a   = 32'd2;
    op_b   = 32'd5;
    ndone  = 0;
    stable = 1'b1;
    l1 = 0; l2 = 0; r1 = '0; r2 = '0;
    for (int c = 1; c <= 40 && ndone < 2; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          l1 = c;
          r1 = result;
        end else begin
          l2    = c;
          r2    = result;
          start = 1'b0;
        end
      end else if (ndone == 0 && result !== prev) begin
        stable = 1'b0;
      end else if (ndone == 1 && result !== r1) begin
        stable = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_ndone", ndone, 2);
    check("b2b_first_result", r1, 12);
    check("b2b_first_latency", l1, 4);
    check("b2b_second_result", r2, 10);
    check("b2b_second_latency", l2, 9);
    check("b2b_result_stable", stable, 1);

    // Random operands against the product model.
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 3 == 0) ra = ra >> $urandom_range(0, 31);
      rb = rb >> $urandom_range(0, 31);
      if (n % 7 == 0) rb = '0;
      model(ra, rb, r2, es, elat);
      do_op(ra, rb, r, s, lat, alu_ok);
      check($sformatf("rnd%0d_result a=%0h b=%0h", n, ra, rb), r, r2);
      check($sformatf("rnd%0d_status", n), s, es);
      check($sformatf("rnd%0d_latency", n), lat, elat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
